uart_tx_stream_arbiter: RTL and testbench



---
 rtl/uart_tx_stream_arbiter_if.sv | 26 ++
 rtl/uart_tx_stream_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_stream_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_stream_arbiter_if.sv
// Stream bundle between NUM_SRC byte producers, the arbiter and the UART TX.
// Ports: s_* per-source AXIS slave side, m_* AXIS master side to UART TX.
interface uart_tx_stream_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_SRC-1:0]            s_tvalid;
    logic [NUM_SRC-1:0]            s_tlast;
    logic [NUM_SRC-1:0]            s_tready;
    logic [DATA_WIDTH-1:0]         m_tdata;
    logic                          m_tvalid;
    logic                          m_tready;

    // Arbiter side: consumes the sources, drives the UART TX stream.
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid
    );

    // Environment side: drives sources and UART ready.
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid
    );
endinterface

// File: rtl/uart_tx_stream_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream among NUM_SRC sources.
// Ports: aclk, aresetn (async low), bus (stream bundle), grant_id, busy.
module uart_tx_stream_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BURST_MAX    = 16,
    parameter int ADD_HEADER   = 1,
    parameter int IDLE_TIMEOUT = 255,
    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    uart_tx_stream_arbiter_if.slave bus,
    output logic [GW-1:0]           grant_id,
    output logic                    busy
);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic                  found;
    logic [GW-1:0]         pick;
    logic                  g_valid;
    logic                  g_last;
    logic                  acc;
    logic [DATA_WIDTH-1:0] m_tdata_c;
    logic                  m_tvalid_c;
    logic [NUM_SRC-1:0]    s_tready_c;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= GW'(NUM_SRC - 1);
            beat_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
        end
    end

    // Scan from the source after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % NUM_SRC;
            if (!found && bus.s_tvalid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    assign g_valid = bus.s_tvalid[grant_q];
    assign g_last  = bus.s_tlast[grant_q];
    assign acc     = g_valid && bus.m_tready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        beat_d     = beat_q;
        tmo_d      = tmo_q;
        m_tvalid_c = 1'b0;
        m_tdata_c  = '0;
        s_tready_c = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    beat_d  = '0;
                    tmo_d   = '0;
                    state_d = (ADD_HEADER != 0) ? HEADER : DATA;
                end
            end
            HEADER: begin
                m_tvalid_c = 1'b1;
                m_tdata_c  = DATA_WIDTH'(8'hA0) | DATA_WIDTH'(grant_q);
                if (bus.m_tready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_tvalid_c = g_valid;
                m_tdata_c  = bus.s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                s_tready_c[grant_q] = bus.m_tready;
                if (acc) begin
                    beat_d = beat_q + 1'b1;
                    if (g_last || beat_q == BW'(BURST_MAX - 1)) begin
                        state_d = IDLE;
                        rr_d    = grant_q;
                    end
                end
                // Idle timer only runs while the granted source is silent.
                if (g_valid) begin
                    tmo_d = '0;
                end else if (IDLE_TIMEOUT != 0) begin
                    if (tmo_q == TW'(IDLE_TIMEOUT - 1)) begin
                        state_d = IDLE;
                        rr_d    = grant_q;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m_tvalid = m_tvalid_c;
    assign bus.m_tdata  = m_tdata_c;
    assign bus.s_tready = s_tready_c;
    assign grant_id     = grant_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_stream_arbiter.sv
// Scoreboard bench for uart_tx_stream_arbiter (4 sources, header on).
// Directed bursts feed per-source queues; a monitor checks every UART beat.
module tb_uart_tx_stream_arbiter;
    logic       clk;
    logic       aresetn;
    logic [1:0] grant_id;
    logic       busy;

    uart_tx_stream_arbiter_if #(.NUM_SRC(4), .DATA_WIDTH(8)) bus ();

    uart_tx_stream_arbiter #(
        .NUM_SRC(4), .DATA_WIDTH(8), .BURST_MAX(16),
        .ADD_HEADER(1), .IDLE_TIMEOUT(255)
    ) dut (
        .aclk(clk), .aresetn(aresetn), .bus(bus),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         gap;
    } beat_t;

    typedef struct {
        logic [7:0] b;
        bit         hdr;
        int         src;
    } exp_t;

    beat_t srcq [4][$];
    int    gapc [4];
    exp_t  sb [$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_acc  = 0;
    int    cyc    = 0;
    int    acc_cyc [0:511];
    bit    tog    = 0;
    bit    stall_q = 0;
    logic [7:0] prev_d;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic exp_hdr(int s);
        sb.push_back('{8'hA0 | 8'(s), 1'b1, s});
    endtask

    task automatic exp_dat(int s, logic [7:0] b);
        sb.push_back('{b, 1'b0, s});
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (srcq[i].size() > 0) begin
                bus.s_tdata[i*8 +: 8] = srcq[i][0].d;
                bus.s_tlast[i]        = srcq[i][0].l;
                bus.s_tvalid[i]       = (gapc[i] == 0);
            end else begin
                bus.s_tvalid[i] = 1'b0;
                bus.s_tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic push(int s, logic [7:0] d, logic l, int gap);
        if (srcq[s].size() == 0) gapc[s] = gap;
        srcq[s].push_back('{d, l, gap});
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            srcq[i].delete();
            gapc[i] = 0;
        end
        drive();
    endtask

    // One clock: sample handshakes mid-cycle, update sources after the edge.
    task automatic step();
        logic [3:0] fire;
        @(negedge clk);
        fire = bus.s_tvalid & bus.s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
                gapc[i] = (srcq[i].size() > 0) ? srcq[i][0].gap : 0;
            end else if (gapc[i] > 0) begin
                gapc[i]--;
            end
        end
        if (tog) bus.m_tready = ~bus.m_tready;
        drive();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_src();
        step();
        step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic wait_done(string nm, int max);
        for (int k = 0; k < max && sb.size() != 0; k++) step();
        chk({nm, "_drained"}, sb.size(), 0);
        for (int k = 0; k < 4; k++) step();
    endtask

    // Monitor: every accepted UART beat is checked against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!aresetn) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", bus.m_tvalid, 1);
                chk("hold_data", bus.m_tdata, prev_d);
            end
            if (bus.m_tvalid && bus.m_tready) begin
                if (n_acc < 512) acc_cyc[n_acc] = cyc;
                n_acc++;
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got %0h expected none", bus.m_tdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("m_tdata", bus.m_tdata, e.b);
                    chk("s_tready", bus.s_tready,
                        e.hdr ? 32'd0 : (32'd1 << e.src));
                    chk("grant_id", grant_id, e.src);
                end
            end
            stall_q = bus.m_tvalid && !bus.m_tready;
            prev_d  = bus.m_tdata;
        end
    end

    initial begin
        int base;
        aresetn       = 1'b0;
        bus.s_tdata   = '0;
        bus.s_tvalid  = '0;
        bus.s_tlast   = '0;
        bus.m_tready  = 1'b1;
        for (int i = 0; i < 4; i++) gapc[i] = 0;
        #12;
        chk("rst_m_tvalid", bus.m_tvalid, 0);
        chk("rst_s_tready", bus.s_tready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // 1: lone source 2, three beats.
        exp_hdr(2); exp_dat(2, 8'h11); exp_dat(2, 8'h22); exp_dat(2, 8'h33);
        push(2, 8'h11, 0, 0); push(2, 8'h22, 0, 0); push(2, 8'h33, 1, 0);
        wait_done("t1", 50);

        // 2: all sources busy, one-beat bursts rotate 0,1,2,3.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++) begin
                push(s, 8'(s * 16 + r + 1), 1, 0);
                exp_hdr(s);
                exp_dat(s, 8'(s * 16 + r + 1));
            end
        wait_done("t2", 100);

        // 3: 40 beats on source 1 split 16/16/8, source 3 interleaved.
        do_reset();
        for (int k = 0; k < 40; k++) push(1, 8'(8'h40 + k), k == 39, 0);
        push(3, 8'hC0, 1, 0);
        push(3, 8'hC1, 1, 0);
        exp_hdr(1);
        for (int k = 0; k < 16; k++) exp_dat(1, 8'(8'h40 + k));
        exp_hdr(3); exp_dat(3, 8'hC0);
        exp_hdr(1);
        for (int k = 16; k < 32; k++) exp_dat(1, 8'(8'h40 + k));
        exp_hdr(3); exp_dat(3, 8'hC1);
        exp_hdr(1);
        for (int k = 32; k < 40; k++) exp_dat(1, 8'(8'h40 + k));
        wait_done("t3", 200);

        // 4: UART ready toggling every cycle.
        do_reset();
        bus.m_tready = 1'b0;
        tog = 1;
        exp_hdr(0); exp_dat(0, 8'h71); exp_dat(0, 8'h72); exp_dat(0, 8'h73);
        push(0, 8'h71, 0, 0); push(0, 8'h72, 0, 0); push(0, 8'h73, 1, 0);
        wait_done("t4", 60);
        tog = 0;
        bus.m_tready = 1'b1;

        // 5: source 0 goes silent mid-burst; grant revoked after 255 cycles.
        do_reset();
        base = n_acc;
        push(0, 8'h51, 0, 0); push(0, 8'h52, 1, 300);
        push(1, 8'h61, 1, 0);
        exp_hdr(0); exp_dat(0, 8'h51);
        exp_hdr(1); exp_dat(1, 8'h61);
        exp_hdr(0); exp_dat(0, 8'h52);
        wait_done("t5", 700);
        chk("t5_revoke_gap", acc_cyc[base + 2] - acc_cyc[base + 1], 257);

        // 6: reset pulsed mid-burst after two data beats.
        do_reset();
        base = n_acc;
        for (int k = 0; k < 5; k++) push(0, 8'(8'h81 + k), k == 4, 0);
        exp_hdr(0); exp_dat(0, 8'h81); exp_dat(0, 8'h82);
        for (int k = 0; k < 50 && n_acc < base + 3; k++) step();
        chk("t6_beats_before_rst", n_acc - base, 3);
        aresetn = 1'b0;
        #1;
        chk("t6_m_tvalid", bus.m_tvalid, 0);
        chk("t6_s_tready", bus.s_tready, 0);
        chk("t6_busy", busy, 0);
        clear_src();
        step();
        step();
        aresetn = 1'b1;
        push(1, 8'h91, 1, 0);
        push(0, 8'h92, 1, 0);
        exp_hdr(0); exp_dat(0, 8'h92);
        exp_hdr(1); exp_dat(1, 8'h91);
        wait_done("t6", 50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
